// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch port, the data port, the shared memory and the arbiter.
//   slave  : arbiter view. It takes the requests and memory responses, and drives the acks,
//            the read data, the memory command and stall.
//   master : requester/memory view, the mirror of slave.
interface mem_arbiter_if;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 3;

    // fetch port
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ack;
    // data port
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [SW-1:0] d_size;
    logic [DW-1:0] d_rdata;
    logic          d_ack;
    logic          d_err;
    // shared memory
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [SW-1:0] mem_size;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    // pipeline hold
    logic          stall;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_size, mem_rdata, mem_ready,
        output if_rdata, if_ack, d_rdata, d_ack, d_err,
               mem_req, mem_we, mem_addr, mem_wdata, mem_size, stall
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_size, mem_rdata, mem_ready,
        input  if_rdata, if_ack, d_rdata, d_ack, d_err,
               mem_req, mem_we, mem_addr, mem_wdata, mem_size, stall
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one shared memory.
// At most one memory transaction is outstanding. A waiting fetch is protected from
// starvation by a saturating counter of data grants.
// Ports:
//   clk   - clock, rising edge
//   rst_n - synchronous active-low reset
//   bus   - mem_arbiter_if.slave: fetch/data request ports, memory command/response, stall
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter bit          DATA_FIRST   = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_arbiter_if.slave bus
);
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 3;
    localparam int unsigned CW = 3;

    localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);
    localparam logic [SW-1:0] SIZE_WORD  = SW'(3'b010);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [SW-1:0] mem_size_q, mem_size_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          if_ack_q, if_ack_d;
    logic          d_ack_q, d_ack_d;
    logic          d_err_q, d_err_d;
    logic [CW-1:0] starve_q, starve_d;

    logic if_elig;
    logic d_elig;
    logic grant_i;
    logic grant_d;
    logic d_misaligned;

    // A port stays ineligible in the cycle its ack is shown, so a held request is not re-granted.
    assign if_elig = bus.if_req & ~if_ack_q;
    assign d_elig  = bus.d_req & ~d_ack_q;

    // Data wins ties only when preferred and the fetch has not hit its starvation limit.
    assign grant_d = (state_q == IDLE) && d_elig &&
                     (!if_elig || (DATA_FIRST && (starve_q != STARVE_MAX)));
    assign grant_i = (state_q == IDLE) && if_elig && !grant_d;

    // Half access on an odd address, or word access not on a 4-byte boundary.
    assign d_misaligned = ((bus.d_size[1:0] == 2'b01) && bus.d_addr[0]) ||
                          ((bus.d_size[1:0] == 2'b10) && (bus.d_addr[1:0] != 2'b00));

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_size_d  = mem_size_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        d_err_d     = 1'b0;
        starve_d    = starve_q;

        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    if (bus.if_req && (starve_q != STARVE_MAX)) begin
                        starve_d = starve_q + CW'(1);
                    end
                    if (d_misaligned) begin
                        // Answered locally; the memory is never touched.
                        d_ack_d   = 1'b1;
                        d_err_d   = 1'b1;
                        d_rdata_d = '0;
                    end else begin
                        state_d     = BUSY_D;
                        mem_req_d   = 1'b1;
                        mem_we_d    = bus.d_we;
                        mem_addr_d  = bus.d_addr;
                        mem_wdata_d = bus.d_wdata;
                        mem_size_d  = bus.d_size;
                    end
                end else if (grant_i) begin
                    starve_d    = '0;
                    state_d     = BUSY_I;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = bus.if_addr;
                    mem_wdata_d = '0;
                    mem_size_d  = SIZE_WORD;
                end
            end
            BUSY_I: begin
                if (bus.mem_ready) begin
                    if_rdata_d = bus.mem_rdata;
                    if_ack_d   = 1'b1;
                    mem_req_d  = 1'b0;
                    state_d    = IDLE;
                end
            end
            BUSY_D: begin
                if (bus.mem_ready) begin
                    d_rdata_d = bus.mem_rdata;
                    d_ack_d   = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_size_q  <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            d_err_q     <= 1'b0;
            starve_q    <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_size_q  <= mem_size_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            d_err_q     <= d_err_d;
            starve_q    <= starve_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_size  = mem_size_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.d_err     = d_err_q;

    // Hold the pipeline while any request is still waiting for its ack.
    assign bus.stall = (bus.if_req & ~if_ack_q) | (bus.d_req & ~d_ack_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter.
// It runs directed scenarios with literal expectations, then randomized requesters and memory.
// A transaction-level reference model checks every output on every cycle.
module tb_mem_arbiter;
    localparam int STARVE_LIMIT = 2;
    localparam bit DATA_FIRST   = 1'b1;
    localparam int RAND_CYCLES  = 4000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if bus();

    mem_arbiter #(
        .STARVE_LIMIT(STARVE_LIMIT),
        .DATA_FIRST  (DATA_FIRST)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference model: who owns the memory (0 none, 1 fetch, 2 data) and what each output must show.
    int          m_owner  = 0;
    int          m_starve = 0;
    logic        m_mem_req = 1'b0, m_mem_we = 1'b0;
    logic [31:0] m_mem_addr = '0, m_mem_wdata = '0, m_if_rdata = '0, m_d_rdata = '0;
    logic [2:0]  m_mem_size = '0;
    logic        m_if_ack = 1'b0, m_d_ack = 1'b0, m_d_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // An access is misaligned when the address is not a multiple of the access size in bytes.
    function automatic bit misaligned(input logic [31:0] addr, input logic [2:0] size);
        int nbytes;
        logic [1:0] low;
        low = addr[1:0];
        nbytes = (size[1:0] == 2'b00) ? 1 : (size[1:0] == 2'b01) ? 2 : 4;
        return (int'(low) % nbytes) != 0;
    endfunction

    always @(posedge clk) begin : ref_model
        bit fetch_waiting, data_waiting, data_served;
        if (!rst_n) begin
            m_owner     <= 0;
            m_starve    <= 0;
            m_mem_req   <= 1'b0;
            m_mem_we    <= 1'b0;
            m_mem_addr  <= '0;
            m_mem_wdata <= '0;
            m_mem_size  <= '0;
            m_if_rdata  <= '0;
            m_d_rdata   <= '0;
            m_if_ack    <= 1'b0;
            m_d_ack     <= 1'b0;
            m_d_err     <= 1'b0;
        end else begin
            m_if_ack <= 1'b0;
            m_d_ack  <= 1'b0;
            m_d_err  <= 1'b0;
            if (m_owner == 0) begin
                fetch_waiting = bus.if_req && !m_if_ack;
                data_waiting  = bus.d_req && !m_d_ack;
                data_served   = data_waiting &&
                                (!fetch_waiting || (DATA_FIRST && (m_starve < STARVE_LIMIT)));
                if (data_served) begin
                    if (bus.if_req)
                        m_starve <= (m_starve + 1 > STARVE_LIMIT) ? STARVE_LIMIT : m_starve + 1;
                    if (misaligned(bus.d_addr, bus.d_size)) begin
                        m_d_ack   <= 1'b1;
                        m_d_err   <= 1'b1;
                        m_d_rdata <= '0;
                    end else begin
                        m_owner     <= 2;
                        m_mem_req   <= 1'b1;
                        m_mem_we    <= bus.d_we;
                        m_mem_addr  <= bus.d_addr;
                        m_mem_wdata <= bus.d_wdata;
                        m_mem_size  <= bus.d_size;
                    end
                end else if (fetch_waiting) begin
                    m_starve    <= 0;
                    m_owner     <= 1;
                    m_mem_req   <= 1'b1;
                    m_mem_we    <= 1'b0;
                    m_mem_addr  <= bus.if_addr;
                    m_mem_wdata <= '0;
                    m_mem_size  <= 3'b010;
                end
            end else if (bus.mem_ready) begin
                if (m_owner == 1) begin
                    m_if_rdata <= bus.mem_rdata;
                    m_if_ack   <= 1'b1;
                end else begin
                    m_d_rdata <= bus.mem_rdata;
                    m_d_ack   <= 1'b1;
                end
                m_mem_req <= 1'b0;
                m_owner   <= 0;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("mem_req",   32'(bus.mem_req),   32'(m_mem_req));
            chk("mem_we",    32'(bus.mem_we),    32'(m_mem_we));
            chk("mem_addr",  bus.mem_addr,       m_mem_addr);
            chk("mem_wdata", bus.mem_wdata,      m_mem_wdata);
            chk("mem_size",  32'(bus.mem_size),  32'(m_mem_size));
            chk("if_ack",    32'(bus.if_ack),    32'(m_if_ack));
            chk("if_rdata",  bus.if_rdata,       m_if_rdata);
            chk("d_ack",     32'(bus.d_ack),     32'(m_d_ack));
            chk("d_err",     32'(bus.d_err),     32'(m_d_err));
            chk("d_rdata",   bus.d_rdata,        m_d_rdata);
            chk("stall",     32'(bus.stall),
                32'((bus.if_req & ~m_if_ack) | (bus.d_req & ~m_d_ack)));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    logic [2:0] sizes [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    task automatic new_fetch();
        bus.if_req  = 1'b1;
        bus.if_addr = $urandom() & 32'hFFFF_FFFC;
    endtask

    task automatic new_data();
        bus.d_req   = 1'b1;
        bus.d_we    = 1'($urandom_range(0, 1));
        bus.d_addr  = $urandom();
        bus.d_wdata = $urandom();
        bus.d_size  = sizes[$urandom_range(0, 4)];
    endtask

    initial begin
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_size = '0;
        bus.mem_ready = 1'b0; bus.mem_rdata = '0;
        rst_n = 1'b0;
        tick();
        tick();
        chk_en = 1'b1;
        chk("reset mem_req", 32'(bus.mem_req), 32'd0);
        chk("reset d_ack",   32'(bus.d_ack),   32'd0);
        chk("reset if_rdata", bus.if_rdata,    32'd0);
        rst_n = 1'b1;

        // Zero-wait fetch
        bus.if_req = 1'b1; bus.if_addr = 32'h100; bus.mem_ready = 1'b1; bus.mem_rdata = 32'h13;
        tick();
        chk("fetch c1 mem_req",  32'(bus.mem_req), 32'd1);
        chk("fetch c1 mem_addr", bus.mem_addr,     32'h100);
        chk("fetch c1 mem_size", 32'(bus.mem_size), 32'd2);
        tick();
        chk("fetch c2 if_ack",   32'(bus.if_ack),  32'd1);
        chk("fetch c2 if_rdata", bus.if_rdata,     32'h13);
        chk("fetch c2 stall",    32'(bus.stall),   32'd0);
        bus.if_req = 1'b0; bus.mem_ready = 1'b0;
        tick();
        chk("fetch c3 if_ack",   32'(bus.if_ack),  32'd0);

        // Simultaneous requests with two wait states; data goes first
        bus.if_req = 1'b1; bus.if_addr = 32'h300;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h200; bus.d_size = 3'b010;
        bus.mem_rdata = 32'hABCD_0000;
        tick();
        chk("both c1 mem_addr", bus.mem_addr, 32'h200);
        tick();
        tick();
        chk("both c3 mem_req", 32'(bus.mem_req), 32'd1);
        chk("both c3 d_ack",   32'(bus.d_ack),   32'd0);
        bus.mem_ready = 1'b1;
        tick();
        chk("both c4 d_ack",   32'(bus.d_ack),   32'd1);
        chk("both c4 d_rdata", bus.d_rdata,      32'hABCD_0000);
        chk("both c4 mem_req", 32'(bus.mem_req), 32'd0);
        bus.mem_ready = 1'b0;
        tick();
        chk("both c5 mem_addr", bus.mem_addr, 32'h300);
        bus.d_req = 1'b0; bus.mem_rdata = 32'h93;
        tick();
        tick();
        bus.mem_ready = 1'b1;
        tick();
        chk("both c8 if_ack",   32'(bus.if_ack), 32'd1);
        chk("both c8 if_rdata", bus.if_rdata,    32'h93);
        bus.if_req = 1'b0; bus.mem_ready = 1'b0;
        tick();

        // Misaligned word load
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h202; bus.d_size = 3'b010;
        tick();
        chk("misal d_ack",   32'(bus.d_ack),   32'd1);
        chk("misal d_err",   32'(bus.d_err),   32'd1);
        chk("misal d_rdata", bus.d_rdata,      32'd0);
        chk("misal mem_req", 32'(bus.mem_req), 32'd0);
        bus.d_req = 1'b0;
        tick();
        chk("misal after d_err", 32'(bus.d_err), 32'd0);

        // Reset while a store waits on memory, then a stray mem_ready while idle
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h400; bus.d_size = 3'b010;
        bus.d_wdata = 32'hDEAD_BEEF;
        tick();
        chk("store mem_we",    32'(bus.mem_we), 32'd1);
        chk("store mem_wdata", bus.mem_wdata,   32'hDEAD_BEEF);
        rst_n = 1'b0;
        tick();
        chk("rst mid mem_req",   32'(bus.mem_req),  32'd0);
        chk("rst mid d_ack",     32'(bus.d_ack),    32'd0);
        chk("rst mid mem_addr",  bus.mem_addr,      32'd0);
        chk("rst mid mem_wdata", bus.mem_wdata,     32'd0);
        chk("rst mid if_rdata",  bus.if_rdata,      32'd0);
        rst_n = 1'b1; bus.d_req = 1'b0; bus.mem_ready = 1'b1;
        tick();
        tick();
        chk("idle ready d_ack",   32'(bus.d_ack),   32'd0);
        chk("idle ready if_ack",  32'(bus.if_ack),  32'd0);
        chk("idle ready mem_req", 32'(bus.mem_req), 32'd0);
        bus.mem_ready = 1'b0;

        // Randomized traffic, occasional reset
        for (int cyc = 0; cyc < RAND_CYCLES; cyc++) begin
            rst_n = ($urandom_range(0, 249) != 0);
            if (bus.if_req && m_if_ack) begin
                if ($urandom_range(0, 1) == 1) new_fetch(); else bus.if_req = 1'b0;
            end else if (!bus.if_req && ($urandom_range(0, 2) == 0)) begin
                new_fetch();
            end
            if (bus.d_req && m_d_ack) begin
                if ($urandom_range(0, 1) == 1) new_data(); else bus.d_req = 1'b0;
            end else if (!bus.d_req && ($urandom_range(0, 2) == 0)) begin
                new_data();
            end
            bus.mem_ready = ($urandom_range(0, 2) != 0);
            bus.mem_rdata = $urandom();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
